aes444_sched: RTL and testbench

AES444_SCHED -- requirements
Module: aes444_sched

---
 rtl/aes444_pkg.sv | 28 ++
 rtl/aes444_sched_if.sv | 56 +++++
 rtl/aes444_lfsr64.sv | 30 +++
 rtl/aes444_sched.sv | 126 ++++++++++++
 tb/tb_aes444_sched.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes444_pkg.sv
// aes444_pkg: shared types and constants for the AES444 mask scheduler.
//   state_t       - scheduler FSM states
//   CORE_LAT_DEF  - default core latency in cycles
//   LFSR_TAPS     - Galois feedback mask for x^64+x^63+x^61+x^60+1
//   DATA_W/RBITS_W - key/text/mask width and random-bit width
package aes444_pkg;

  localparam int DATA_W       = 64;
  localparam int RBITS_W      = 360;
  localparam int REFILL_WORDS = 8;
  localparam int CORE_LAT_DEF = 44;

  // Right-shifting Galois form: feedback bit positions are exponent-1.
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REFILL,
    START,
    WAIT,
    DONE
  } state_t;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/aes444_sched_if.sv
// aes444_sched_if: bundles the requester, reseed, core and result
// handshake signals of the AES444 scheduler.
//   slave  - the scheduler side (consumes requests, drives the core)
//   master - the environment side (requesters, core, result sink)
interface aes444_sched_if;
  import aes444_pkg::*;

  logic                req0_valid;
  logic                req1_valid;
  logic [DATA_W-1:0]   req0_key;
  logic [DATA_W-1:0]   req1_key;
  logic [DATA_W-1:0]   req0_text;
  logic [DATA_W-1:0]   req1_text;
  logic                req0_ready;
  logic                req1_ready;

  logic [DATA_W-1:0]   seed_in;
  logic                seed_load;

  logic                core_start;
  logic [DATA_W-1:0]   core_key_in;
  logic [DATA_W-1:0]   core_text_in;
  logic [DATA_W-1:0]   core_t_mask;
  logic [DATA_W-1:0]   core_k_mask;
  logic [RBITS_W-1:0]  core_r_bits;
  logic [DATA_W-1:0]   core_text_out;

  logic                out_valid;
  logic                out_id;
  logic [DATA_W-1:0]   out_data;
  logic                out_ready;
  logic                busy;

  modport slave (
    input  req0_valid, req1_valid, req0_key, req1_key, req0_text, req1_text,
    output req0_ready, req1_ready,
    input  seed_in, seed_load,
    output core_start, core_key_in, core_text_in, core_t_mask, core_k_mask, core_r_bits,
    input  core_text_out,
    output out_valid, out_id, out_data,
    input  out_ready,
    output busy
  );

  modport master (
    output req0_valid, req1_valid, req0_key, req1_key, req0_text, req1_text,
    input  req0_ready, req1_ready,
    output seed_in, seed_load,
    input  core_start, core_key_in, core_text_in, core_t_mask, core_k_mask, core_r_bits,
    output core_text_out,
    input  out_valid, out_id, out_data,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/aes444_lfsr64.sv
// aes444_lfsr64: 64-bit Galois LFSR supplying mask randomness.
//   clk, rst - clock and synchronous active-high reset (state -> SEED_DEF)
//   load     - replace state with seed (zero seed maps to SEED_DEF)
//   step     - advance one position
//   q        - current state
module aes444_lfsr64
  import aes444_pkg::*;
#(
  parameter logic [63:0] SEED_DEF = 64'h0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] q
);

  // An all-zero state would lock the LFSR, so a zero seed falls back to SEED_DEF.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED_DEF;
    end else if (load) begin
      q <= (seed == 64'h0) ? SEED_DEF : seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/aes444_sched.sv
// aes444_sched: arbitrates two requesters onto one masked AES444 core.
// Each operation refills a mask buffer from the LFSR (8 cycles), pulses
// core_start, waits CORE_LAT cycles, captures the result and holds it
// until out_ready.
//   clk, rst - clock and synchronous active-high reset
//   bus      - aes444_sched_if.slave: requests, reseed, core link, result
module aes444_sched
  import aes444_pkg::*;
#(
  parameter int          CORE_LAT = CORE_LAT_DEF,
  parameter logic [63:0] SEED_DEF = 64'h0000_0000_0000_0001
) (
  input logic           clk,
  input logic           rst,
  aes444_sched_if.slave bus
);

  // Only the low 488 bits of the 512-bit shift buffer are ever used, so
  // the discarded top 24 bits are not stored.
  localparam int KEEP_W = 2 * DATA_W + RBITS_W;

  state_t              state;
  logic [15:0]         cnt;
  logic                prio;
  logic                id_r;
  logic [KEEP_W-1:0]   mask_buf;
  logic                gnt_any;
  logic                gnt_id;
  logic                lfsr_load;
  logic                lfsr_step;
  logic [DATA_W-1:0]   lfsr_q;

  // Grant is a same-cycle decode so the request is consumed when ready is seen.
  assign gnt_any = !rst && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign gnt_id  = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;

  assign bus.req0_ready = gnt_any && !gnt_id;
  assign bus.req1_ready = gnt_any && gnt_id;

  // Reseed is honoured only in IDLE; it lands on the same edge as a grant
  // so the following REFILL already draws from the new seed.
  assign lfsr_load = (state == IDLE) && bus.seed_load;
  assign lfsr_step = (state == REFILL);

  assign bus.core_t_mask = mask_buf[DATA_W-1:0];
  assign bus.core_k_mask = mask_buf[2*DATA_W-1:DATA_W];
  assign bus.core_r_bits = mask_buf[KEEP_W-1:2*DATA_W];

  aes444_lfsr64 #(
    .SEED_DEF(SEED_DEF)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (bus.seed_in),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Each REFILL cycle shifts in the current LFSR word while the LFSR steps.
  // The counter is shared: refill word index, then WAIT cycle index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      prio             <= 1'b0;
      id_r             <= 1'b0;
      mask_buf         <= '0;
      bus.core_start   <= 1'b0;
      bus.core_key_in  <= '0;
      bus.core_text_in <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_id       <= 1'b0;
      bus.out_data     <= '0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            bus.core_key_in  <= gnt_id ? bus.req1_key  : bus.req0_key;
            bus.core_text_in <= gnt_id ? bus.req1_text : bus.req0_text;
            id_r             <= gnt_id;
            prio             <= !gnt_id;
            cnt              <= '0;
            bus.busy         <= 1'b1;
            state            <= REFILL;
          end
        end
        REFILL: begin
          mask_buf <= {mask_buf[KEEP_W-DATA_W-1:0], lfsr_q};
          if (cnt == 16'(REFILL_WORDS - 1)) begin
            cnt            <= '0;
            bus.core_start <= 1'b1;
            state          <= START;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        START: begin
          bus.core_start <= 1'b0;
          cnt            <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          if (cnt == 16'(CORE_LAT - 1)) begin
            bus.out_data  <= bus.core_text_out;
            bus.out_id    <= id_r;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes444_sched.sv
// tb_aes444_sched: randomized self-checking bench for aes444_sched.
// A behavioural core stub returns a toy cipher of the unmasked key/text
// exactly CORE_LAT cycles after core_start and random junk otherwise.
// A reference model tracks LFSR state and arbitration priority.
module tb_aes444_sched;
  import aes444_pkg::*;

  localparam int          LAT    = 44;
  localparam logic [63:0] SEED_D = 64'h0000_0000_0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [63:0] m_lfsr;
  bit          m_prio;

  aes444_sched_if bus();

  aes444_sched #(
    .CORE_LAT(LAT),
    .SEED_DEF(SEED_D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Toy cipher used as the golden result of the core.
  function automatic logic [63:0] toy(input logic [63:0] k, input logic [63:0] t);
    logic [63:0] x;
    x = t;
    for (int r = 0; r < 4; r++) begin
      x = x ^ k;
      x = {x[50:0], x[63:51]};
      x = x + (k >> r) + 64'(r);
    end
    return x;
  endfunction

  // Reference LFSR: multiply by x^-1 modulo x^64+x^63+x^61+x^60+1.
  function automatic logic [63:0] model_step(input logic [63:0] s);
    logic [63:0] fb;
    fb = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);
    return s[0] ? ((s >> 1) ^ fb) : (s >> 1);
  endfunction

  function automatic logic [63:0] tmask_for_seed(input logic [63:0] seed);
    logic [63:0] w;
    w = (seed == 64'h0) ? SEED_D : seed;
    for (int i = 0; i < 7; i++) w = model_step(w);
    return w;
  endfunction

  // Core stub: registered-style result, valid only in the exact cycle.
  int          core_cnt = 0;
  logic [63:0] stub_key, stub_text, junk;

  always @(posedge clk) begin
    junk <= rnd64();
    if (rst) begin
      core_cnt <= 0;
    end else if (bus.core_start) begin
      core_cnt  <= 1;
      stub_key  <= bus.core_key_in;
      stub_text <= bus.core_text_in;
    end else if (core_cnt != 0 && core_cnt < 1000) begin
      core_cnt <= core_cnt + 1;
    end
  end

  always_comb begin
    bus.core_text_out = junk;
    if (core_cnt == LAT) bus.core_text_out = toy(stub_key, stub_text);
  end

  task automatic checkOutput(input string tag, input logic [359:0] obs, input logic [359:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.seed_load  = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED_D;
    m_prio = 1'b0;
  endtask

  task automatic loadSeed(input logic [63:0] seed);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.seed_load  = 1'b1;
    bus.seed_in    = seed;
    @(negedge clk);
    bus.seed_load  = 1'b0;
    m_lfsr = (seed == 64'h0) ? SEED_D : seed;
  endtask

  // One full operation from grant to result handshake, checked against the model.
  task automatic applyStimulus(
    input  bit          v0,
    input  bit          v1,
    input  logic [63:0] k0, input logic [63:0] t0,
    input  logic [63:0] k1, input logic [63:0] t1,
    input  bit          seed_now,
    input  logic [63:0] seed,
    input  int          stall,
    input  int          reseed_at,
    output int          gid,
    output logic [63:0] data,
    output logic [63:0] tm,
    output logic [63:0] km,
    output logic [359:0] rb
  );
    int          gcyc, off, starts;
    bit          got;
    logic [63:0] words [8];
    logic [63:0] ek, et;
    data = '0; tm = '0; km = '0; rb = '0;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_key = k0; bus.req0_text = t0;
    bus.req1_valid = v1; bus.req1_key = k1; bus.req1_text = t1;
    bus.seed_load  = seed_now;
    bus.seed_in    = seed;
    bus.out_ready  = 1'b0;
    #1;
    gid = (v0 && v1) ? int'(m_prio) : (v1 ? 1 : 0);
    checkOutput("grant0", bus.req0_ready, gid == 0);
    checkOutput("grant1", bus.req1_ready, gid == 1);
    gcyc = cyc;
    if (seed_now) m_lfsr = (seed == 64'h0) ? SEED_D : seed;
    for (int i = 0; i < 8; i++) begin
      words[i] = m_lfsr;
      m_lfsr   = model_step(m_lfsr);
    end
    m_prio = (gid == 0);
    ek = (gid == 1) ? k1 : k0;
    et = (gid == 1) ? t1 : t0;
    starts = 0;
    got    = 1'b0;
    off    = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      off = cyc - gcyc;
      bus.req0_valid = 1'b1; bus.req0_key = rnd64(); bus.req0_text = rnd64();
      bus.req1_valid = 1'b1; bus.req1_key = rnd64(); bus.req1_text = rnd64();
      bus.seed_load  = (off == reseed_at);
      bus.seed_in    = rnd64() | 64'h1;
      #1;
      checkOutput("no_grant", {bus.req0_ready, bus.req1_ready}, 2'b00);
      checkOutput("busy_op", bus.busy, 1'b1);
      if (bus.core_start) begin
        starts++;
        checkOutput("start_off", off, 9);
        checkOutput("key_in", bus.core_key_in, ek);
        checkOutput("text_in", bus.core_text_in, et);
        tm = bus.core_t_mask;
        km = bus.core_k_mask;
        rb = bus.core_r_bits;
      end
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) begin
      checkOutput("timeout", 1'b0, 1'b1);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.seed_load = 1'b0;
      return;
    end
    checkOutput("start_count", starts, 1);
    checkOutput("valid_off", off, 10 + LAT);
    checkOutput("out_id", bus.out_id, gid);
    checkOutput("out_data", bus.out_data, toy(ek, et));
    checkOutput("t_mask", tm, words[7]);
    checkOutput("k_mask", km, words[6]);
    checkOutput("r_bits", rb, {words[0][39:0], words[1], words[2], words[3], words[4], words[5]});
    data = bus.out_data;
    bus.seed_load = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      checkOutput("hold_valid", bus.out_valid, 1'b1);
      checkOutput("hold_data", bus.out_data, toy(ek, et));
      checkOutput("hold_busy", bus.busy, 1'b1);
      checkOutput("hold_no_grant", {bus.req0_ready, bus.req1_ready}, 2'b00);
    end
    bus.out_ready  = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("done_valid", bus.out_valid, 1'b0);
    checkOutput("done_busy", bus.busy, 1'b0);
    bus.out_ready = 1'b0;
  endtask

  // Reset while the core is running: everything drops, nothing comes out later.
  task automatic resetMidOp();
    int gcyc, seen;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_key = rnd64(); bus.req0_text = rnd64();
    bus.req1_valid = 1'b0;
    #1;
    checkOutput("rst_op_grant", bus.req0_ready, 1'b1);
    gcyc = cyc;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    while (cyc - gcyc < 25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_core_start", bus.core_start, 1'b0);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_state", dut.state == IDLE, 1'b1);
    checkOutput("rst_t_mask", bus.core_t_mask, 64'h0);
    rst = 1'b0;
    m_lfsr = SEED_D;
    m_prio = 1'b0;
    seen = 0;
    repeat (LAT + 20) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("rst_no_stale", seen, 0);
  endtask

  initial begin
    int           g;
    int           gids [3];
    logic [63:0]  d, tm, km, k, t, s;
    logic [359:0] rb;
    bit           v0, v1;

    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_key = '0; bus.req1_key = '0; bus.req0_text = '0; bus.req1_text = '0;
    bus.seed_in = '0; bus.seed_load = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_out_valid", bus.out_valid, 1'b0);
    checkOutput("reset_core_start", bus.core_start, 1'b0);
    checkOutput("reset_out_data", bus.out_data, 64'h0);
    checkOutput("reset_key_in", bus.core_key_in, 64'h0);
    checkOutput("reset_lfsr", dut.u_lfsr.q, SEED_D);
    doReset();

    $display("[TB] single request");
    applyStimulus(1, 0, 64'hFEDCBA9876543210, 64'h0, '0, '0, 0, '0, 0, -1, g, d, tm, km, rb);
    checkOutput("single_id", g, 0);

    $display("[TB] simultaneous requests");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, rnd64(), rnd64(), rnd64(), rnd64(), 0, '0, 0, -1, g, d, tm, km, rb);
      gids[i] = g;
    end
    checkOutput("rr_order", {gids[0][0], gids[1][0], gids[2][0]}, 3'b010);

    $display("[TB] backpressure");
    applyStimulus(0, 1, rnd64(), rnd64(), rnd64(), rnd64(), 0, '0, 20, -1, g, d, tm, km, rb);

    $display("[TB] seeding");
    loadSeed(64'h0);
    @(negedge clk);
    checkOutput("seed_zero_lfsr", dut.u_lfsr.q, SEED_D);
    k = rnd64();
    t = rnd64();
    s = 64'h0123_4567_89AB_CDEF;
    applyStimulus(1, 0, k, t, '0, '0, 1, s, 0, -1, g, d, tm, km, rb);
    applyStimulus(1, 0, k, t, '0, '0, 1, s, 0, -1, g, d, tm, km, rb);
    checkOutput("same_seed_t", tm, tmask_for_seed(s));
    applyStimulus(1, 0, k, t, '0, '0, 1, 64'hA5A5_0F0F_3C3C_9696, 0, -1, g, d, tm, km, rb);
    checkOutput("diff_seed_t", tm == tmask_for_seed(s), 1'b0);
    checkOutput("diff_seed_data", d, toy(k, t));
    applyStimulus(0, 1, rnd64(), rnd64(), k, t, 1, 64'h0, 0, -1, g, d, tm, km, rb);
    checkOutput("zero_seed_t", tm, tmask_for_seed(64'h0));

    $display("[TB] seed during refill");
    applyStimulus(1, 0, rnd64(), rnd64(), '0, '0, 0, '0, 0, 4, g, d, tm, km, rb);
    applyStimulus(1, 0, rnd64(), rnd64(), '0, '0, 0, '0, 1, -1, g, d, tm, km, rb);

    $display("[TB] reset mid-operation");
    resetMidOp();
    applyStimulus(1, 1, rnd64(), rnd64(), rnd64(), rnd64(), 0, '0, 0, -1, g, d, tm, km, rb);
    checkOutput("post_rst_id", g, 0);

    $display("[TB] random operations");
    for (int i = 0; i < 8; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      s = ($urandom_range(0, 3) == 0) ? 64'h0 : rnd64();
      applyStimulus(v0, v1, rnd64(), rnd64(), rnd64(), rnd64(),
                    1'($urandom_range(0, 1)), s, int'($urandom_range(0, 3)), -1,
                    g, d, tm, km, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
